// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: register-file sizes, tag types and
// free-list pointer helpers. Used by both the free list and the RAT.
package rename_pkg;

    localparam int unsigned NUM_ARCH_REGS = 35;  // includes LO=33 and HI=34
    localparam int unsigned NUM_PHYS_REGS = 64;

    localparam int unsigned LOG_ARCH = $clog2(NUM_ARCH_REGS);
    localparam int unsigned LOG_PHYS = $clog2(NUM_PHYS_REGS);

    // Tags 0..NUM_ARCH_REGS-1 belong to the RAT at reset; the rest start free.
    localparam int unsigned FL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int unsigned FL_PTR_W = $clog2(FL_DEPTH);
    localparam int unsigned FL_CNT_W = $clog2(FL_DEPTH + 1);

    typedef logic [LOG_ARCH-1:0] arch_reg_t;
    typedef logic [LOG_PHYS-1:0] phys_tag_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_CNT_W-1:0] fl_cnt_t;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t p);
        return (p == fl_ptr_t'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/free_list_if.sv
// Renamer/retirement <-> free list signal bundle.
interface free_list_if;
    import rename_pkg::*;

    logic      alloc_req;
    logic      alloc_valid;
    phys_tag_t alloc_tag;
    logic      commit;
    logic      free_valid;
    phys_tag_t free_tag;
    logic      flush;
    fl_cnt_t   spec_count;
    logic      error;

    // Pipeline side: requests allocations, retires, releases, flushes.
    modport master (
        output alloc_req, commit, free_valid, free_tag, flush,
        input  alloc_valid, alloc_tag, spec_count, error
    );

    // Free list side.
    modport slave (
        input  alloc_req, commit, free_valid, free_tag, flush,
        output alloc_valid, alloc_tag, spec_count, error
    );

endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of tags with a speculative
// head (advanced by allocation) and a committed head (advanced by
// retirement). Flush rolls the speculative head back to the committed one.
module free_list
    import rename_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    free_list_if.slave fl
);

    fl_ptr_t   s_head_q, s_head_d;
    fl_ptr_t   c_head_q, c_head_d;
    fl_ptr_t   tail_q,   tail_d;
    fl_cnt_t   spec_count_q, spec_count_d;
    fl_cnt_t   c_count_q,    c_count_d;
    logic      error_q,      error_d;
    phys_tag_t mem_q [FL_DEPTH];

    fl_cnt_t   in_flight;
    logic      alloc_valid;
    logic      alloc_fire;
    logic      commit_ok;
    logic      free_ok;

    // Allocation outputs depend on registered state only.
    assign alloc_valid    = (spec_count_q != '0);
    assign fl.alloc_valid = alloc_valid;
    assign fl.alloc_tag   = mem_q[s_head_q];
    assign fl.spec_count  = spec_count_q;
    assign fl.error       = error_q;

    // Event legality and next-state for pointers, counters and error flag.
    always_comb begin
        in_flight  = c_count_q - spec_count_q;
        alloc_fire = fl.alloc_req && alloc_valid && !fl.flush;
        commit_ok  = fl.commit && (in_flight != '0);
        free_ok    = fl.free_valid
                  && (c_count_q < fl_cnt_t'(FL_DEPTH))
                  && (fl.free_tag != '0);

        error_d = error_q
               || (fl.commit && !commit_ok)
               || (fl.free_valid && !free_ok);

        c_head_d  = commit_ok ? fl_ptr_inc(c_head_q) : c_head_q;
        tail_d    = free_ok   ? fl_ptr_inc(tail_q)   : tail_q;
        c_count_d = c_count_q - fl_cnt_t'(commit_ok) + fl_cnt_t'(free_ok);

        // Flush targets are taken after this cycle's commit/free.
        if (fl.flush) begin
            s_head_d     = c_head_d;
            spec_count_d = c_count_d;
        end else begin
            s_head_d     = alloc_fire ? fl_ptr_inc(s_head_q) : s_head_q;
            spec_count_d = spec_count_q + fl_cnt_t'(free_ok) - fl_cnt_t'(alloc_fire);
        end
    end

    // Pointer, counter and sticky-error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_head_q     <= '0;
            c_head_q     <= '0;
            tail_q       <= '0;
            spec_count_q <= fl_cnt_t'(FL_DEPTH);
            c_count_q    <= fl_cnt_t'(FL_DEPTH);
            error_q      <= 1'b0;
        end else begin
            s_head_q     <= s_head_d;
            c_head_q     <= c_head_d;
            tail_q       <= tail_d;
            spec_count_q <= spec_count_d;
            c_count_q    <= c_count_d;
            error_q      <= error_d;
        end
    end

    // Tag storage: loaded with the non-architectural tags on reset, single
    // write port at the tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= phys_tag_t'(NUM_ARCH_REGS + i);
            end
        end else if (free_ok) begin
            mem_q[tail_q] <= fl.free_tag;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list. The reference model keeps the
// committed free tags as a queue plus a count of in-flight allocations.
module tb_free_list;
    import rename_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    free_list_if ifc();

    free_list dut (
        .clk   (clk),
        .reset (rst),
        .fl    (ifc)
    );

    always #5 clk = ~clk;

    // Reference model: mq holds tags from committed head to tail; the first
    // m_inflight entries are speculatively allocated.
    int mq[$];
    int m_inflight;
    bit m_err;

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < int'(FL_DEPTH); i++) mq.push_back(int'(NUM_ARCH_REGS) + i);
        m_inflight = 0;
        m_err = 1'b0;
    endtask

    function automatic int exp_cnt();
        return mq.size() - m_inflight;
    endfunction

    function automatic int exp_tag();
        return (m_inflight < mq.size()) ? mq[m_inflight] : -1;
    endfunction

    task automatic clear_inputs();
        ifc.alloc_req  = 1'b0;
        ifc.commit     = 1'b0;
        ifc.free_valid = 1'b0;
        ifc.free_tag   = '0;
        ifc.flush      = 1'b0;
    endtask

    // Update the model from the inputs currently driven, clock once, then
    // return at the falling edge with inputs idle.
    task automatic tick();
        bit afire, cok, fok;
        if (rst) begin
            model_reset();
        end else begin
            afire = ifc.alloc_req && (exp_cnt() > 0) && !ifc.flush;
            cok   = ifc.commit && (m_inflight > 0);
            fok   = ifc.free_valid && (mq.size() < int'(FL_DEPTH)) && (ifc.free_tag != 0);
            if (ifc.commit && !cok) m_err = 1'b1;
            if (ifc.free_valid && !fok) m_err = 1'b1;
            if (cok) begin
                void'(mq.pop_front());
                m_inflight--;
            end
            if (fok) mq.push_back(int'(ifc.free_tag));
            if (ifc.flush) m_inflight = 0;
            else if (afire) m_inflight++;
        end
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.alloc_req = 1'b1;
            tick();
        end
    endtask

    task automatic commit_n(input int n);
        for (int i = 0; i < n; i++) begin
            ifc.commit = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        // Reset must win over every other input.
        rst = 1'b1;
        ifc.alloc_req = 1'b1; ifc.commit = 1'b1; ifc.free_valid = 1'b1;
        ifc.free_tag = 6'd9; ifc.flush = 1'b1;
        tick();
        rst = 1'b1;
        ifc.alloc_req = 1'b1; ifc.free_valid = 1'b1; ifc.free_tag = 6'd3;
        tick();
        rst = 1'b0;
        n_checks++;
        if (ifc.alloc_valid !== 1'b1 || ifc.alloc_tag !== phys_tag_t'(35)
            || ifc.spec_count !== fl_cnt_t'(29) || ifc.error !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got valid=%0b tag=%0d cnt=%0d err=%0b, expected 1/35/29/0",
                     ifc.alloc_valid, ifc.alloc_tag, ifc.spec_count, ifc.error);
        end
    endtask

    task automatic test_drain();
        apply_reset();
        for (int i = 0; i < 29; i++) begin
            n_checks++;
            if (ifc.alloc_valid !== 1'b1 || ifc.alloc_tag !== phys_tag_t'(35 + i)) begin
                n_errors++;
                $display("FAIL drain_tag[%0d]: got valid=%0b tag=%0d, expected valid=1 tag=%0d",
                         i, ifc.alloc_valid, ifc.alloc_tag, 35 + i);
            end
            ifc.alloc_req = 1'b1;
            tick();
        end
        n_checks++;
        if (ifc.alloc_valid !== 1'b0 || ifc.spec_count !== fl_cnt_t'(0)) begin
            n_errors++;
            $display("FAIL drain_empty: got valid=%0b cnt=%0d, expected 0/0",
                     ifc.alloc_valid, ifc.spec_count);
        end
        ifc.alloc_req = 1'b1;
        tick();
        n_checks++;
        if (ifc.spec_count !== fl_cnt_t'(0) || ifc.error !== 1'b0) begin
            n_errors++;
            $display("FAIL alloc_when_empty: got cnt=%0d err=%0b, expected 0/0",
                     ifc.spec_count, ifc.error);
        end
    endtask

    task automatic test_free_empty();
        apply_reset();
        alloc_n(29);
        commit_n(1);
        ifc.free_valid = 1'b1; ifc.free_tag = 6'd7; ifc.alloc_req = 1'b1;
        #1;
        n_checks++;
        if (ifc.alloc_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL no_bypass_same_cycle: got valid=%0b, expected 0", ifc.alloc_valid);
        end
        tick();
        n_checks++;
        if (ifc.alloc_valid !== 1'b1 || ifc.alloc_tag !== phys_tag_t'(7)
            || ifc.spec_count !== fl_cnt_t'(1)) begin
            n_errors++;
            $display("FAIL no_bypass_next: got valid=%0b tag=%0d cnt=%0d, expected 1/7/1",
                     ifc.alloc_valid, ifc.alloc_tag, ifc.spec_count);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        alloc_n(5);
        commit_n(2);
        ifc.flush = 1'b1;
        tick();
        n_checks++;
        if (ifc.alloc_tag !== phys_tag_t'(37) || ifc.spec_count !== fl_cnt_t'(27)) begin
            n_errors++;
            $display("FAIL flush_restore: got tag=%0d cnt=%0d, expected 37/27",
                     ifc.alloc_tag, ifc.spec_count);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ifc.alloc_tag !== phys_tag_t'(37 + i)) begin
                n_errors++;
                $display("FAIL flush_realloc[%0d]: got tag=%0d, expected %0d",
                         i, ifc.alloc_tag, 37 + i);
            end
            ifc.alloc_req = 1'b1;
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            ifc.commit = 1'b1;
            tick();
            n_checks++;
            if (ifc.error !== ((k == 3) ? 1'b1 : 1'b0)) begin
                n_errors++;
                $display("FAIL commit_limit[%0d]: got err=%0b, expected %0b",
                         k, ifc.error, (k == 3));
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        alloc_n(29);
        commit_n(29);
        for (int t = 10; t <= 38; t++) begin
            ifc.free_valid = 1'b1;
            ifc.free_tag   = phys_tag_t'(t);
            tick();
        end
        n_checks++;
        if (ifc.spec_count !== fl_cnt_t'(29) || ifc.error !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_refill: got cnt=%0d err=%0b, expected 29/0",
                     ifc.spec_count, ifc.error);
        end
        for (int i = 0; i < 29; i++) begin
            n_checks++;
            if (ifc.alloc_valid !== 1'b1 || ifc.alloc_tag !== phys_tag_t'(10 + i)) begin
                n_errors++;
                $display("FAIL wrap_tag[%0d]: got valid=%0b tag=%0d, expected valid=1 tag=%0d",
                         i, ifc.alloc_valid, ifc.alloc_tag, 10 + i);
            end
            ifc.alloc_req = 1'b1;
            tick();
        end
        n_checks++;
        if (ifc.error !== 1'b0 || ifc.alloc_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_end: got err=%0b valid=%0b, expected 0/0",
                     ifc.error, ifc.alloc_valid);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        alloc_n(5);
        commit_n(2);
        // 3 in flight, committed count 27.
        ifc.alloc_req = 1'b1; ifc.commit = 1'b1; ifc.free_valid = 1'b1;
        ifc.free_tag = 6'd5; ifc.flush = 1'b1;
        tick();
        n_checks++;
        if (ifc.spec_count !== fl_cnt_t'(27) || ifc.alloc_tag !== phys_tag_t'(38)
            || ifc.error !== 1'b0) begin
            n_errors++;
            $display("FAIL all_events: got cnt=%0d tag=%0d err=%0b, expected 27/38/0",
                     ifc.spec_count, ifc.alloc_tag, ifc.error);
        end
    endtask

    task automatic test_free_errors();
        apply_reset();
        ifc.free_valid = 1'b1; ifc.free_tag = 6'd12;
        tick();
        n_checks++;
        if (ifc.error !== 1'b1 || ifc.spec_count !== fl_cnt_t'(29)
            || ifc.alloc_tag !== phys_tag_t'(35)) begin
            n_errors++;
            $display("FAIL free_when_full: got err=%0b cnt=%0d tag=%0d, expected 1/29/35",
                     ifc.error, ifc.spec_count, ifc.alloc_tag);
        end
        apply_reset();
        n_checks++;
        if (ifc.error !== 1'b0) begin
            n_errors++;
            $display("FAIL error_cleared_by_reset: got err=%0b, expected 0", ifc.error);
        end
        alloc_n(1);
        commit_n(1);
        ifc.free_valid = 1'b1; ifc.free_tag = 6'd0;
        tick();
        n_checks++;
        if (ifc.error !== 1'b1 || ifc.spec_count !== fl_cnt_t'(28)) begin
            n_errors++;
            $display("FAIL free_tag_zero: got err=%0b cnt=%0d, expected 1/28",
                     ifc.error, ifc.spec_count);
        end
        ifc.free_valid = 1'b1; ifc.free_tag = 6'd40;
        tick();
        alloc_n(28);
        n_checks++;
        if (ifc.alloc_valid !== 1'b1 || ifc.alloc_tag !== phys_tag_t'(40)
            || ifc.spec_count !== fl_cnt_t'(1)) begin
            n_errors++;
            $display("FAIL zero_not_stored: got valid=%0b tag=%0d cnt=%0d, expected 1/40/1",
                     ifc.alloc_valid, ifc.alloc_tag, ifc.spec_count);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst            = ($urandom_range(0, 79) == 0);
            ifc.alloc_req  = ($urandom_range(0, 3) != 0);
            ifc.commit     = ($urandom_range(0, 1) == 0);
            ifc.free_valid = ($urandom_range(0, 3) == 0);
            ifc.free_tag   = phys_tag_t'($urandom_range(0, 63));
            ifc.flush      = ($urandom_range(0, 19) == 0);
            tick();
            rst = 1'b0;
            n_checks++;
            if (ifc.alloc_valid !== (exp_cnt() != 0)
                || ifc.spec_count !== fl_cnt_t'(exp_cnt())
                || ifc.error !== m_err
                || (exp_cnt() != 0 && ifc.alloc_tag !== phys_tag_t'(exp_tag()))) begin
                n_errors++;
                $display("FAIL random[%0d]: got valid=%0b tag=%0d cnt=%0d err=%0b, expected valid=%0b tag=%0d cnt=%0d err=%0b",
                         cyc, ifc.alloc_valid, ifc.alloc_tag, ifc.spec_count, ifc.error,
                         (exp_cnt() != 0), exp_tag(), exp_cnt(), m_err);
            end
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_drain();
        test_free_empty();
        test_flush();
        test_wrap();
        test_simultaneous();
        test_free_errors();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
